// File: rtl/hmmm_pkg.sv
// Shared definitions for the HMMM decode stage.
// Holds the opcode encoding, instruction field widths, register-file depth,
// the ALU operand bundle layout and the immediate sign-extension helper.
package hmmm_pkg;

  localparam int unsigned NREGS   = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned IMM_W   = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_SETN = 4'h1,
    OP_ADDN = 4'h5,
    OP_ADD  = 4'h6,
    OP_SUB  = 4'h7
  } opcode_e;

  // Operand bundle handed to the ALU stage (result = b + a or b - a).
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              alu_ctrl;
    logic [REG_AW-1:0] rd;
    logic              we;
  } ex_bundle_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] n);
    return {{(DATA_W-IMM_W){n[IMM_W-1]}}, n};
  endfunction

endpackage

// File: rtl/hmmm_decode_if.sv
// Bus bundle for hmmm_decode: instruction input handshake, ALU-stage operand
// output handshake, write-back strobe and the illegal-opcode pulse.
//   master : instruction source / ALU stage / write-back driver
//   slave  : the decode stage
interface hmmm_decode_if;
  import hmmm_pkg::*;

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;

  logic               ex_valid;
  logic               ex_ready;
  logic [DATA_W-1:0]  ex_a;
  logic [DATA_W-1:0]  ex_b;
  logic               ex_aluCtrl;
  logic [REG_AW-1:0]  ex_rd;
  logic               ex_we;

  logic               wb_en;
  logic [REG_AW-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  logic               illegal;

  modport master (
    output in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
    input  in_ready, ex_valid, ex_a, ex_b, ex_aluCtrl, ex_rd, ex_we, illegal
  );

  modport slave (
    input  in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
    output in_ready, ex_valid, ex_a, ex_b, ex_aluCtrl, ex_rd, ex_we, illegal
  );

endinterface

// File: rtl/hmmm_regfile.sv
// HMMM register file: two combinational read ports, one write port.
// r0 is hardwired to zero; writes to it are dropped.
//   clk, reset_n          : clock, async active-low reset (clears all regs)
//   src0_addr/src0_data_c : read port 0
//   src1_addr/src1_data_c : read port 1
//   wr_en/wr_addr/wr_data : write port, committed on the next rising edge
module hmmm_regfile #(
  parameter int unsigned NREGS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  src0_addr,
  output logic [15:0] src0_data_c,
  input  logic [3:0]  src1_addr,
  output logic [15:0] src1_data_c,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data
);
  import hmmm_pkg::*;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state of the array; r0 forced to zero regardless of writes.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign src0_data_c = (src0_addr == '0) ? '0 : regs_q[src0_addr];
  assign src1_data_c = (src1_addr == '0) ? '0 : regs_q[src1_addr];

endmodule

// File: rtl/hmmm_decode.sv
// HMMM decode stage: accepts instruction words, reads operands from the
// register file (with write-through bypass from the write-back port),
// tracks outstanding destinations in a pending scoreboard and issues a
// registered operand bundle to the ALU stage.
//   clk, reset_n : clock, async active-low reset
//   bus          : hmmm_decode_if slave (in_*, ex_*, wb_*, illegal)
module hmmm_decode #(
  parameter int unsigned NREGS = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  hmmm_decode_if.slave  bus
);
  import hmmm_pkg::*;

  // Instruction fields
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] fx;
  logic [REG_AW-1:0] fy;
  logic [REG_AW-1:0] fz;
  logic [IMM_W-1:0]  fn;

  assign op = bus.in_instr[15:12];
  assign fx = bus.in_instr[11:8];
  assign fy = bus.in_instr[7:4];
  assign fz = bus.in_instr[3:0];
  assign fn = bus.in_instr[7:0];

  logic              dec_issue;
  logic              dec_illegal;
  logic              use_src0;
  logic              use_src1;
  logic              use_dst;
  logic [REG_AW-1:0] src0_addr;
  logic [REG_AW-1:0] src1_addr;
  logic [DATA_W-1:0] src0_rf;
  logic [DATA_W-1:0] src1_rf;
  logic [DATA_W-1:0] src0_val;
  logic [DATA_W-1:0] src1_val;

  // Opcode decode and register-read address selection.
  always_comb begin
    dec_issue   = 1'b0;
    dec_illegal = 1'b0;
    use_src0    = 1'b0;
    use_src1    = 1'b0;
    use_dst     = 1'b0;
    src0_addr   = '0;
    src1_addr   = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        dec_issue = 1'b1;
        use_src0  = 1'b1;
        use_src1  = 1'b1;
        use_dst   = 1'b1;
        src0_addr = fy;
        src1_addr = fz;
      end
      OP_ADDN: begin
        dec_issue = 1'b1;
        use_src0  = 1'b1;
        use_dst   = 1'b1;
        src0_addr = fx;
      end
      OP_SETN: begin
        dec_issue = 1'b1;
        use_dst   = 1'b1;
      end
      OP_NOP: begin
        // Only the all-zero word is a nop; other 0x0xxx words are unsupported.
        if (bus.in_instr == '0) begin
          dec_issue = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  hmmm_regfile #(.NREGS(NREGS)) u_rf (
    .clk         (clk),
    .reset_n     (reset_n),
    .src0_addr   (src0_addr),
    .src0_data_c (src0_rf),
    .src1_addr   (src1_addr),
    .src1_data_c (src1_rf),
    .wr_en       (bus.wb_en),
    .wr_addr     (bus.wb_addr),
    .wr_data     (bus.wb_data)
  );

  // Write-through bypass: a same-cycle write-back to a source wins over the array.
  always_comb begin
    src0_val = src0_rf;
    src1_val = src1_rf;
    if (bus.wb_en && (bus.wb_addr == src0_addr) && (src0_addr != '0)) begin
      src0_val = bus.wb_data;
    end
    if (bus.wb_en && (bus.wb_addr == src1_addr) && (src1_addr != '0)) begin
      src1_val = bus.wb_data;
    end
  end

  ex_bundle_t new_bundle;

  // Operand bundle for the instruction currently offered.
  always_comb begin
    new_bundle = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        new_bundle.b        = src0_val;
        new_bundle.a        = src1_val;
        new_bundle.alu_ctrl = (op == OP_SUB);
        new_bundle.rd       = fx;
        new_bundle.we       = (fx != '0);
      end
      OP_ADDN: begin
        new_bundle.b  = src0_val;
        new_bundle.a  = sext_imm(fn);
        new_bundle.rd = fx;
        new_bundle.we = (fx != '0);
      end
      OP_SETN: begin
        new_bundle.a  = sext_imm(fn);
        new_bundle.rd = fx;
        new_bundle.we = (fx != '0);
      end
      default: new_bundle = '0;
    endcase
  end

  ex_bundle_t       ex_q,       ex_d;
  logic             ex_valid_q, ex_valid_d;
  logic             illegal_q,  illegal_d;
  logic [NREGS-1:0] pending_q,  pending_d;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] pend_eff;
  logic [NREGS-1:0] set_mask;
  logic             hazard;
  logic             in_ready_c;
  logic             in_fire;

  // Scoreboard view with this cycle's write-back already retired.
  always_comb begin
    wb_clr   = bus.wb_en ? (NREGS'(1) << bus.wb_addr) : '0;
    pend_eff = pending_q & ~wb_clr;
    hazard   = (use_src0 && pend_eff[src0_addr]) ||
               (use_src1 && pend_eff[src1_addr]) ||
               (use_dst  && pend_eff[fx]);
  end

  assign in_ready_c = (!ex_valid_q || bus.ex_ready) && !hazard;
  assign in_fire    = bus.in_valid && in_ready_c;

  // Next-state for output bundle, illegal pulse and pending bits.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q && !bus.ex_ready;
    illegal_d  = in_fire && dec_illegal;
    set_mask   = '0;
    if (in_fire && dec_issue) begin
      ex_d       = new_bundle;
      ex_valid_d = 1'b1;
      if (new_bundle.we) begin
        set_mask = NREGS'(1) << fx;
      end
    end
    // Set is applied after clear so a coinciding set wins.
    pending_d = pend_eff | set_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      pending_q  <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      illegal_q  <= illegal_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_a       = ex_q.a;
  assign bus.ex_b       = ex_q.b;
  assign bus.ex_aluCtrl = ex_q.alu_ctrl;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_we      = ex_q.we;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_hmmm_decode.sv
// Directed self-checking bench for hmmm_decode.
module tb_hmmm_decode;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  hmmm_decode_if bus ();

  hmmm_decode #(.NREGS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic [15:0] b, input logic [15:0] a,
                        input logic ctrl, input logic [3:0] rd, input logic we);
    chk({tag, ".valid"}, 32'(bus.ex_valid),   32'(1'b1));
    chk({tag, ".b"},     32'(bus.ex_b),       32'(b));
    chk({tag, ".a"},     32'(bus.ex_a),       32'(a));
    chk({tag, ".ctrl"},  32'(bus.ex_aluCtrl), 32'(ctrl));
    chk({tag, ".rd"},    32'(bus.ex_rd),      32'(rd));
    chk({tag, ".we"},    32'(bus.ex_we),      32'(we));
  endtask

  task automatic chk_pend(input string tag, input logic [15:0] exp);
    chk({tag, ".pending"}, 32'(dut.pending_q), 32'(exp));
  endtask

  task automatic wb(input logic en, input logic [3:0] addr, input logic [15:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  task automatic offer(input logic v, input logic [15:0] instr);
    bus.in_valid = v;
    bus.in_instr = instr;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    offer(1'b0, 16'h0000);
    wb(1'b0, 4'h0, 16'h0000);
    bus.ex_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst.ex_valid", 32'(bus.ex_valid), 32'(1'b0));
    chk("rst.illegal",  32'(bus.illegal),  32'(1'b0));
    chk("rst.ex_a",     32'(bus.ex_a),     32'(16'h0));
    chk("rst.ex_b",     32'(bus.ex_b),     32'(16'h0));
    chk("rst.ex_rd",    32'(bus.ex_rd),    32'(4'h0));
    chk("rst.ex_we",    32'(bus.ex_we),    32'(1'b0));
    chk_pend("rst", 16'h0000);
    reset_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(bus.in_ready), 32'(1'b1));

    // setn r1 5 -> b=0 a=5
    offer(1'b1, 16'h1105);
    #1;
    chk("setn.in_ready", 32'(bus.in_ready), 32'(1'b1));
    tick();
    chk_ex("setn_r1", 16'h0000, 16'h0005, 1'b0, 4'h1, 1'b1);
    chk_pend("setn_r1", 16'h0002);

    // write back r1=5 while the bundle drains
    offer(1'b0, 16'h0000);
    wb(1'b1, 4'h1, 16'h0005);
    tick();
    chk("drain.ex_valid", 32'(bus.ex_valid), 32'(1'b0));
    chk_pend("wb_r1", 16'h0000);

    // add r2 r1 r1 -> b=5 a=5 rd=2
    wb(1'b0, 4'h0, 16'h0000);
    offer(1'b1, 16'h6211);
    #1;
    chk("add.in_ready", 32'(bus.in_ready), 32'(1'b1));
    tick();
    chk_ex("add_r2", 16'h0005, 16'h0005, 1'b0, 4'h2, 1'b1);
    chk_pend("add_r2", 16'h0004);

    // r2=3, then r1=10
    offer(1'b0, 16'h0000);
    wb(1'b1, 4'h2, 16'h0003);
    tick();
    wb(1'b1, 4'h1, 16'h000A);
    tick();
    wb(1'b0, 4'h0, 16'h0000);
    chk_pend("wb_r2_r1", 16'h0000);

    // sub r3 r1 r2 -> b=10 a=3 ctrl=1
    offer(1'b1, 16'h7312);
    tick();
    chk_ex("sub_r3", 16'h000A, 16'h0003, 1'b1, 4'h3, 1'b1);
    offer(1'b0, 16'h0000);
    wb(1'b1, 4'h3, 16'h0007);
    tick();
    wb(1'b0, 4'h0, 16'h0000);

    // addn r1 -1 -> b=10 a=0xFFFF
    offer(1'b1, 16'h51FF);
    tick();
    chk_ex("addn_r1", 16'h000A, 16'hFFFF, 1'b0, 4'h1, 1'b1);

    // add r2 r1 r0 stalls on pending r1
    offer(1'b1, 16'h6210);
    #1;
    chk("haz0.in_ready", 32'(bus.in_ready), 32'(1'b0));
    tick();
    chk("haz1.ex_valid", 32'(bus.ex_valid), 32'(1'b0));
    chk("haz1.in_ready", 32'(bus.in_ready), 32'(1'b0));
    tick();
    chk("haz2.in_ready", 32'(bus.in_ready), 32'(1'b0));
    chk_pend("haz2", 16'h0002);

    // release with write-back r1=9; bypass supplies it
    wb(1'b1, 4'h1, 16'h0009);
    #1;
    chk("release.in_ready", 32'(bus.in_ready), 32'(1'b1));
    tick();
    chk_ex("bypass", 16'h0009, 16'h0000, 1'b0, 4'h2, 1'b1);
    chk_pend("bypass", 16'h0004);

    // ALU stalls for 3 cycles with a new instruction waiting
    wb(1'b0, 4'h0, 16'h0000);
    bus.ex_ready = 1'b0;
    offer(1'b1, 16'h1501);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.in_ready", 32'(bus.in_ready), 32'(1'b0));
      tick();
      chk_ex("stall", 16'h0009, 16'h0000, 1'b0, 4'h2, 1'b1);
      chk_pend("stall", 16'h0004);
    end

    // reset during the stall
    reset_n = 1'b0;
    offer(1'b0, 16'h0000);
    #1;
    chk("rst2.ex_valid", 32'(bus.ex_valid), 32'(1'b0));
    chk("rst2.ex_b",     32'(bus.ex_b),     32'(16'h0));
    chk_pend("rst2", 16'h0000);
    tick();
    reset_n = 1'b1;
    bus.ex_ready = 1'b1;
    #1;
    chk("rel2.in_ready", 32'(bus.in_ready), 32'(1'b1));
    chk("rel2.ex_valid", 32'(bus.ex_valid), 32'(1'b0));

    // registers were cleared: add r4 r1 r2 -> 0, 0
    offer(1'b1, 16'h6412);
    tick();
    chk_ex("post_rst", 16'h0000, 16'h0000, 1'b0, 4'h4, 1'b1);
    chk_pend("post_rst", 16'h0010);

    // unsupported opcode 0xF123
    offer(1'b1, 16'hF123);
    #1;
    chk("ill.in_ready", 32'(bus.in_ready), 32'(1'b1));
    tick();
    chk("ill.illegal",  32'(bus.illegal),  32'(1'b1));
    chk("ill.ex_valid", 32'(bus.ex_valid), 32'(1'b0));
    offer(1'b0, 16'h0000);
    tick();
    chk("ill2.illegal",  32'(bus.illegal),  32'(1'b0));
    chk("ill2.ex_valid", 32'(bus.ex_valid), 32'(1'b0));
    chk_pend("ill2", 16'h0010);

    // setn r0 7 -> we=0, then back-to-back nop
    offer(1'b1, 16'h1007);
    tick();
    chk_ex("setn_r0", 16'h0000, 16'h0007, 1'b0, 4'h0, 1'b0);
    chk_pend("setn_r0", 16'h0010);
    offer(1'b1, 16'h0000);
    tick();
    chk_ex("nop", 16'h0000, 16'h0000, 1'b0, 4'h0, 1'b0);
    chk("nop.illegal", 32'(bus.illegal), 32'(1'b0));

    // 0x0001 is not a nop
    offer(1'b1, 16'h0001);
    tick();
    chk("ill0001.illegal",  32'(bus.illegal),  32'(1'b1));
    chk("ill0001.ex_valid", 32'(bus.ex_valid), 32'(1'b0));

    // wb r4 coincides with setn r4 3: accepted, set wins
    offer(1'b1, 16'h1403);
    wb(1'b1, 4'h4, 16'h0077);
    #1;
    chk("setwin.in_ready", 32'(bus.in_ready), 32'(1'b1));
    tick();
    chk_ex("setwin", 16'h0000, 16'h0003, 1'b0, 4'h4, 1'b1);
    chk_pend("setwin", 16'h0010);

    // wb to r0 is neither stored nor bypassed
    offer(1'b1, 16'h6500);
    wb(1'b1, 4'h0, 16'h0055);
    tick();
    chk_ex("r0_wb", 16'h0000, 16'h0000, 1'b0, 4'h5, 1'b1);
    chk_pend("r0_wb", 16'h0030);
    offer(1'b1, 16'h6600);
    wb(1'b0, 4'h0, 16'h0000);
    tick();
    chk_ex("r0_read", 16'h0000, 16'h0000, 1'b0, 4'h6, 1'b1);

    offer(1'b0, 16'h0000);
    tick();
    chk("end.ex_valid", 32'(bus.ex_valid), 32'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hmmm_decode.md
HMMM_DECODE -- requirements
Module: hmmm_decode

Interface
REQ-001 SHALL have parameter NREGS, default 16, register-file depth; only 16 is supported.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have in_valid  input  1  instruction word offered.
REQ-005 SHALL have in_instr  input  16  HMMM instruction word.
REQ-006 SHALL have in_ready  output  1  instruction accepted when in_valid && in_ready.
REQ-007 SHALL have ex_valid  output  1  operand bundle valid for the ALU stage.
REQ-008 SHALL have ex_ready  input  1  ALU stage consumes the bundle.
REQ-009 SHALL have ex_a, ex_b  output  16 each  ALU operands; the ALU produces b+a or b-a.
REQ-010 SHALL have ex_aluCtrl  output  1  0 = add, 1 = subtract.
REQ-011 SHALL have ex_rd  output  4  destination register.
REQ-012 SHALL have ex_we  output  1  result is to be written back.
REQ-013 SHALL have wb_en  input  1  write-back strobe.
REQ-014 SHALL have wb_addr  input  4  write-back register.
REQ-015 SHALL have wb_data  input  16  write-back value.
REQ-016 SHALL have illegal  output  1  one-cycle pulse on an accepted unsupported opcode.

Function
REQ-017 Decode SHALL be: 0110 X Y Z = add; 0111 X Y Z = sub; 0001 X n = setn; 0101 X n = addn; 0x0000 = nop.
REQ-018 Operands SHALL be: add/sub b=rY, a=rZ; addn b=rX, a=sext(n); setn b=0, a=sext(n), ctrl=0; ex_rd=X.
REQ-019 nop SHALL issue a bundle with ex_we=0 and zero operands; other opcodes SHALL pulse illegal and issue nothing.
REQ-020 r0 SHALL read as 0; an issue or write-back targeting r0 SHALL produce ex_we=0 and no register change.
REQ-021 Output bundle SHALL be registered: latency 1 cycle from acceptance to ex_valid.
REQ-022 ex_valid SHALL stay high with stable payload until ex_ready; it SHALL clear after a handshake unless a new instruction is accepted the same cycle.
REQ-023 A per-register pending bit SHALL be set when a bundle with ex_we=1 is accepted and cleared on wb_en to that register.
REQ-024 in_ready SHALL equal (!ex_valid || ex_ready) && !hazard.
REQ-025 hazard SHALL be true when any source register or the destination is pending, excluding a register cleared by wb_en in the same cycle.
REQ-026 On wb_en to a source register in the same cycle as issue, the SHALL forward wb_data as that operand (write-through bypass).
REQ-027 When set and clear of the same pending bit coincide, set SHALL win.
REQ-028 Register writes SHALL occur on the clk edge following a wb_en cycle.

Reset
REQ-029 While reset_n is low: ex_valid=0, illegal=0, all pending bits=0, all registers=0, ex_* payload=0.
REQ-030 Asserting reset mid-stall or mid-handshake SHALL discard the held bundle; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-031 The package hmmm_pkg SHALL hold the opcode enum, field-slice widths and the NREGS constant.
REQ-032 The register file SHALL be the sub-module hmmm_regfile (2 read ports, 1 write port, r0 hardwired to zero).

Verification
REQ-033 setn r1 5, then wb r1=5, then add r2 r1 r1 -> first bundle b=0, a=5, ctrl=0; third bundle b=5, a=5, rd=2.
REQ-034 sub r3 r1 r2 with r1=10, r2=3 -> ex_b=10, ex_a=3, ex_aluCtrl=1, rd=3, we=1.
REQ-035 addn r1 -1 issued, then add r2 r1 r0 -> in_ready low until wb_en r1, and the bypass supplies wb_data in the release cycle.
REQ-036 ex_ready held low for 3 cycles with a bundle pending -> payload stable, in_ready=0, no pending-bit change.
REQ-037 Opcode 0xF123 accepted -> illegal pulses for 1 cycle, ex_valid stays 0; setn r0 7 -> ex_we=0.
REQ-038 reset_n low during a stall -> ex_valid=0 and all pending bits cleared, registers read 0.
